// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the ID/EX boundary: RAW forwarding, load-use bubbles, multi-cycle ALU2 hold.
// Latency: all stall/flush/forward outputs are combinational; only the ALU2 FSM state and down-counter are registered.
// Backpressure: a busy multi-cycle op freezes PC, IF/ID and ID/EX and bubbles EX/MEM; a load-use hazard freezes PC and IF/ID and bubbles ID/EX.
module pipeline_hazard_ctrl #(
    parameter int                        REGISTER_SIZE  = 6,
    parameter int                        ALU_FUNCT_BITS = 3,
    parameter int                        MULTI_LATENCY  = 4,
    parameter logic [ALU_FUNCT_BITS-1:0] MULTI_OP_A     = 3'b110,
    parameter logic [ALU_FUNCT_BITS-1:0] MULTI_OP_B     = 3'b111
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    // decode-stage sources
    input  logic [REGISTER_SIZE-1:0]  RsD,
    input  logic [REGISTER_SIZE-1:0]  RtD,
    input  logic [REGISTER_SIZE-1:0]  RuD,
    input  logic                      UseRsD,
    input  logic                      UseRtD,
    input  logic                      UseRuD,
    // execute-stage contents of ID/EX
    input  logic [REGISTER_SIZE-1:0]  RsE,
    input  logic [REGISTER_SIZE-1:0]  RtE,
    input  logic [REGISTER_SIZE-1:0]  RuE,
    input  logic                      ValidE,
    input  logic                      RegWriteE,
    input  logic                      MemReadE,
    input  logic [REGISTER_SIZE-1:0]  WriteRegE,
    input  logic [ALU_FUNCT_BITS-1:0] ALU2CntrlE,
    // later-stage writers
    input  logic                      RegWriteM,
    input  logic [REGISTER_SIZE-1:0]  WriteRegM,
    input  logic                      RegWriteW,
    input  logic [REGISTER_SIZE-1:0]  WriteRegW,
    // pipeline register controls
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic [1:0]                ForwardCE,
    output logic                      ALU2BusyE,
    output logic                      ALU2DoneE
);

    // Operand select encodings for the EX-stage bypass muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // The counter holds the number of further busy cycles after the first one;
    // the start cycle itself is busy combinationally, and the cnt==0 cycle is the done cycle.
    localparam int         CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (MULTI_LATENCY > 1) ? CNT_W'(MULTI_LATENCY - 2) : '0;
    localparam logic       MULTI_EN = (MULTI_LATENCY > 1);

    localparam logic [REGISTER_SIZE-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu2_state_t;

    alu2_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   is_multi_op;
    logic                   multi_start;
    logic                   busy_raw;
    logic                   done_raw;
    logic                   load_use;
    logic [1:0]             fwd_a, fwd_b, fwd_c;

    // Bypass select for one EX operand; the younger MEM result beats the older WB result,
    // and register 0 never forwards because it is hardwired to zero.
    function automatic logic [1:0] fwd_sel(
        input logic [REGISTER_SIZE-1:0] src,
        input logic                     wr_m,
        input logic [REGISTER_SIZE-1:0] reg_m,
        input logic                     wr_w,
        input logic [REGISTER_SIZE-1:0] reg_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (reg_m != REG_ZERO) && (reg_m == src)) begin
            sel = FWD_MEM;
        end else if (wr_w && (reg_w != REG_ZERO) && (reg_w == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Forwarding selects for the three EX operands.
    always_comb begin
        fwd_a = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        fwd_b = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        fwd_c = fwd_sel(RuE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    end

    // Load in EX whose destination is read by the instruction in decode.
    always_comb begin
        load_use = 1'b0;
        if (ValidE && MemReadE && RegWriteE && (WriteRegE != REG_ZERO)) begin
            load_use = (UseRsD && (RsD == WriteRegE)) ||
                       (UseRtD && (RtD == WriteRegE)) ||
                       (UseRuD && (RuD == WriteRegE));
        end
    end

    // ALU2 sequencing: next state, counter and busy/done indications.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_raw    = 1'b0;
        is_multi_op = (ALU2CntrlE == MULTI_OP_A) || (ALU2CntrlE == MULTI_OP_B);
        multi_start = ValidE && (state_q == ST_IDLE) && is_multi_op && MULTI_EN;
        busy_raw    = multi_start || ((state_q == ST_BUSY) && (cnt_q != '0));

        case (state_q)
            ST_IDLE: begin
                if (multi_start) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Final EX cycle: release ID/EX; the op that follows is judged
                    // from IDLE on the next cycle, so this op cannot retrigger itself.
                    done_raw = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers with synchronous reset; reset aborts any op in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pipeline enable/clear controls; a busy op outranks load-use because ID/EX is frozen
    // and the load is re-examined once it is released.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardCE = FWD_RF;
        ALU2BusyE = 1'b0;
        ALU2DoneE = 1'b0;

        if (!RST_N) begin
            // Keep bubbles flowing into EX and MEM while the core is held in reset.
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            ForwardCE = fwd_c;
            ALU2BusyE = busy_raw;
            ALU2DoneE = done_raw;
            if (busy_raw) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: forwarding, load-use, multi-cycle ALU2 and reset.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected output vectors are queued when stimulus is applied and compared when sampled.
module tb_pipeline_hazard_ctrl;

    logic       CLK;
    logic       RST_N;
    logic [5:0] RsD, RtD, RuD;
    logic       UseRsD, UseRtD, UseRuD;
    logic [5:0] RsE, RtE, RuE;
    logic       ValidE, RegWriteE, MemReadE;
    logic [5:0] WriteRegE;
    logic [2:0] ALU2CntrlE;
    logic       RegWriteM;
    logic [5:0] WriteRegM;
    logic       RegWriteW;
    logic [5:0] WriteRegW;
    logic       StallF, StallD, StallE, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE, ForwardCE;
    logic       ALU2BusyE, ALU2DoneE;

    // {StallF,StallD,StallE,FlushE,FlushM, FwdA,FwdB,FwdC, Busy,Done}
    logic [12:0] obs;
    assign obs = {StallF, StallD, StallE, FlushE, FlushM,
                  ForwardAE, ForwardBE, ForwardCE, ALU2BusyE, ALU2DoneE};

    localparam logic [12:0] V_ZERO = 13'b00000_000000_00;
    localparam logic [12:0] V_RST  = 13'b00011_000000_00;
    localparam logic [12:0] V_LU   = 13'b11010_000000_00;
    localparam logic [12:0] V_BUSY = 13'b11101_000000_10;
    localparam logic [12:0] V_DONE = 13'b00000_000000_01;

    logic [12:0] sb [$];
    int checks = 0;
    int passed = 0;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .RsD(RsD), .RtD(RtD), .RuD(RuD),
        .UseRsD(UseRsD), .UseRtD(UseRtD), .UseRuD(UseRuD),
        .RsE(RsE), .RtE(RtE), .RuE(RuE),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .WriteRegE(WriteRegE), .ALU2CntrlE(ALU2CntrlE),
        .RegWriteM(RegWriteM), .WriteRegM(WriteRegM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
        .ALU2BusyE(ALU2BusyE), .ALU2DoneE(ALU2DoneE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RuD = 0;
        UseRsD = 0; UseRtD = 0; UseRuD = 0;
        RsE = 0; RtE = 0; RuE = 0;
        ValidE = 0; RegWriteE = 0; MemReadE = 0;
        WriteRegE = 0; ALU2CntrlE = 3'b000;
        RegWriteM = 0; WriteRegM = 0;
        RegWriteW = 0; WriteRegW = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        RST_N = 1'b0;
        clear_inputs();
        // Inputs that would forward and load-use stall if not in reset.
        RegWriteM = 1; WriteRegM = 6'd5; RsE = 6'd5;
        ValidE = 1; MemReadE = 1; RegWriteE = 1; WriteRegE = 6'd3;
        RtD = 6'd3; UseRtD = 1; ALU2CntrlE = 3'b110;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(V_RST);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL reset_hold[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
        RST_N = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            sb.push_back(V_ZERO);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL reset_release[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
    endtask

    typedef struct packed {
        logic       mw;
        logic [5:0] m;
        logic       ww;
        logic [5:0] w;
        logic [5:0] s, t, u;
        logic [5:0] f;
    } fwd_row_t;

    task automatic test_forward();
        fwd_row_t tbl [8];
        logic [12:0] e;
        tbl[0] = '{1'b1, 6'd5, 1'b1, 6'd5, 6'd5, 6'd5, 6'd9, 6'b10_10_00};
        tbl[1] = '{1'b1, 6'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b00_00_00};
        tbl[2] = '{1'b1, 6'd8, 1'b1, 6'd7, 6'd1, 6'd2, 6'd7, 6'b00_00_01};
        tbl[3] = '{1'b1, 6'd8, 1'b0, 6'd7, 6'd1, 6'd2, 6'd7, 6'b00_00_00};
        tbl[4] = '{1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, 6'b00_00_00};
        tbl[5] = '{1'b0, 6'd8, 1'b1, 6'd8, 6'd8, 6'd1, 6'd8, 6'b01_00_01};
        tbl[6] = '{1'b1, 6'd3, 1'b1, 6'd4, 6'd4, 6'd3, 6'd4, 6'b01_10_01};
        tbl[7] = '{1'b1, 6'd63, 1'b1, 6'd62, 6'd62, 6'd63, 6'd61, 6'b01_10_00};
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            RegWriteM = tbl[i].mw; WriteRegM = tbl[i].m;
            RegWriteW = tbl[i].ww; WriteRegW = tbl[i].w;
            RsE = tbl[i].s; RtE = tbl[i].t; RuE = tbl[i].u;
            sb.push_back({5'b00000, tbl[i].f, 2'b00});
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL forward[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    typedef struct packed {
        logic        v, mr, rw;
        logic [5:0]  we;
        logic [5:0]  rs, rt, ru;
        logic        us, ut, uu;
        logic [12:0] exp;
    } lu_row_t;

    task automatic test_load_use();
        lu_row_t tbl [9];
        logic [12:0] e;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 6'd3, 6'd0, 6'd3, 6'd0, 1'b0, 1'b1, 1'b0, V_LU};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd3, 6'd0, 1'b0, 1'b1, 1'b0, V_ZERO};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 6'd3, 6'd0, 6'd3, 6'd0, 1'b0, 1'b0, 1'b0, V_ZERO};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 6'd3, 6'd0, 6'd0, 6'd3, 1'b0, 1'b0, 1'b1, V_LU};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 6'd3, 6'd3, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, V_LU};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, V_ZERO};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 6'd3, 6'd3, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, V_ZERO};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 6'd3, 6'd3, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, V_ZERO};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 6'd3, 6'd4, 6'd5, 6'd6, 1'b1, 1'b1, 1'b1, V_ZERO};
        clear_inputs();
        for (int i = 0; i < 9; i++) begin
            ValidE = tbl[i].v; MemReadE = tbl[i].mr; RegWriteE = tbl[i].rw;
            WriteRegE = tbl[i].we;
            RsD = tbl[i].rs; RtD = tbl[i].rt; RuD = tbl[i].ru;
            UseRsD = tbl[i].us; UseRtD = tbl[i].ut; UseRuD = tbl[i].uu;
            sb.push_back(tbl[i].exp);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL load_use[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    // One multi-cycle op of the given code held in ID/EX until release, then a plain op.
    task automatic test_multi(input logic [2:0] op);
        logic [12:0] e;
        logic [12:0] seq [5];
        seq[0] = V_BUSY; seq[1] = V_BUSY; seq[2] = V_BUSY; seq[3] = V_DONE; seq[4] = V_ZERO;
        clear_inputs();
        ValidE = 1; ALU2CntrlE = op;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ALU2CntrlE = 3'b000;
            sb.push_back(seq[i]);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL multi_op%b[%0d] got %b want %b", op, i, obs, e);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        clear_inputs();
        ValidE = 1; ALU2CntrlE = 3'b110;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) ALU2CntrlE = 3'b001;
            if (i == 8) sb.push_back(V_ZERO);
            else if ((i % 4) == 3) sb.push_back(V_DONE);
            else sb.push_back(V_BUSY);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL back_to_back[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_multi_load_use();
        logic [12:0] e;
        clear_inputs();
        ValidE = 1; ALU2CntrlE = 3'b110;
        MemReadE = 1; RegWriteE = 1; WriteRegE = 6'd4;
        RsD = 6'd4; UseRsD = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                ValidE = 0; MemReadE = 0; RegWriteE = 0; ALU2CntrlE = 3'b000;
            end
            if (i < 3) sb.push_back(V_BUSY);
            else if (i == 3) sb.push_back(V_LU | V_DONE);
            else sb.push_back(V_ZERO);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL multi_load_use[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        logic [12:0] e;
        clear_inputs();
        ValidE = 1; ALU2CntrlE = 3'b111;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) RST_N = 1'b0;
            if (i == 3) begin
                RST_N = 1'b1;
                ValidE = 0; ALU2CntrlE = 3'b000;
            end
            if (i < 2) sb.push_back(V_BUSY);
            else if (i == 2) sb.push_back(V_RST);
            else sb.push_back(V_ZERO);
            @(negedge CLK);
            e = sb.pop_front(); checks++;
            if (obs !== e) $display("FAIL reset_mid_busy[%0d] got %b want %b", i, obs, e);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        RST_N = 1'b0;
        clear_inputs();
        next_cycle();
        test_reset();
        test_forward();
        test_load_use();
        test_multi(3'b110);
        test_multi(3'b111);
        test_back_to_back();
        test_multi_load_use();
        test_reset_mid_busy();
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the ID/EX pipeline register of the NN CPU.
- Combinational: detects RAW hazards on the three decode-stage source registers (Rs, Rt, Ru → Src1A/B/C); drives EX-stage forwarding selects.
- Sequential: inserts load-use bubbles; holds the ID/EX register for multi-cycle ALU2 operations (MAC, activation) through an FSM and down-counter.
- Outputs drive the enable/clear controls of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
REGISTER_SIZE, 6, register-index width (64 architectural registers; index 0 hardwired zero)
ALU_FUNCT_BITS, 3, width of ALU2 control code
MULTI_LATENCY, 4, EX occupancy in cycles of a multi-cycle ALU2 op; legal range 1..15
MULTI_OP_A, 3'b110, first ALU2 code treated as multi-cycle (MAC)
MULTI_OP_B, 3'b111, second ALU2 code treated as multi-cycle (activation)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
RsD, RtD, RuD  in  REGISTER_SIZE each  decode-stage source indices
UseRsD, UseRtD, UseRuD  in  1 each  source actually read by decode instruction
RsE, RtE, RuE  in  REGISTER_SIZE each  source indices held in ID/EX
ValidE  in  1  ID/EX holds a real instruction (0 = bubble)
RegWriteE, MemReadE  in  1 each  EX-stage control
WriteRegE  in  REGISTER_SIZE  EX destination
ALU2CntrlE  in  ALU_FUNCT_BITS  EX ALU2 code
RegWriteM  in  1; WriteRegM  in  REGISTER_SIZE  MEM-stage writer
RegWriteW  in  1; WriteRegW  in  REGISTER_SIZE  WB-stage writer
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
FlushE  out  1  load bubble into ID/EX on next edge
FlushM  out  1  load bubble into EX/MEM on next edge
ForwardAE, ForwardBE, ForwardCE  out  2 each  operand select: 00 regfile, 10 MEM result, 01 WB result
ALU2BusyE  out  1  multi-cycle op in progress
ALU2DoneE  out  1  final EX cycle of a multi-cycle op

Behaviour:
- Reset (RST_N=0 at rising edge): state←IDLE, cnt←0. While RST_N=0: FlushE=1, FlushM=1; all stalls, forwards, busy, done = 0.
- Forwarding (combinational, per operand X∈{A,B,C} with source SxE):
  - 10 if RegWriteM && WriteRegM≠0 && WriteRegM==SxE.
  - Else 01 if RegWriteW && WriteRegW≠0 && WriteRegW==SxE.
  - Else 00. MEM takes priority over WB.
- multi_start = ValidE && state==IDLE && (ALU2CntrlE==MULTI_OP_A || ALU2CntrlE==MULTI_OP_B) && MULTI_LATENCY>1.
- FSM states: IDLE, BUSY.
  - IDLE→BUSY on multi_start, cnt←MULTI_LATENCY-2.
  - In BUSY: cnt decrements while cnt≠0. When cnt==0: ALU2DoneE=1; next state IDLE.
  - ALU2BusyE = multi_start || (state==BUSY && cnt≠0).
  - Op occupies EX exactly MULTI_LATENCY cycles.
  - Done cycle evaluates no multi_start, so no retrigger. A back-to-back multi op entering EX the following cycle starts normally.
  - MULTI_LATENCY=1: never BUSY; op behaves as single-cycle.
- Multi-cycle stall: while ALU2BusyE=1, StallF=StallD=StallE=1, FlushM=1, FlushE=0.
- Load-use hazard: lu = ValidE && MemReadE && RegWriteE && WriteRegE≠0 && any of (UseRsD && RsD==WriteRegE), (UseRtD && RtD==WriteRegE), (UseRuD && RuD==WriteRegE).
- lu with ALU2BusyE=0: StallF=StallD=1, FlushE=1, StallE=0. Exactly one bubble per load.
- lu with ALU2BusyE=1: the busy rule applies, since ID/EX is held. lu is re-evaluated after release.
- Otherwise all stall/flush outputs are 0.
- Stall/flush outputs are combinational from state and inputs. Only state and cnt are registered.
- Reset mid-BUSY: abort; IDLE on the next edge with no done pulse.

Test Plan:
- Writer R5 in MEM, R5 in WB, RsE=5, RtE=5 → ForwardAE=10, ForwardBE=10; writer R0 in MEM with RsE=0 → ForwardAE=00.
- WB writes R7; RuE=7; MEM writes R8 → ForwardCE=01; clear RegWriteW → ForwardCE=00.
- lw R3 in EX; decode uses Rt=3 with UseRtD=1 → one cycle of StallF=StallD=FlushE=1, then 0. Same case with UseRtD=0 → no stall.
- ALU2CntrlE=110, ValidE=1, MULTI_LATENCY=4 → StallF/D/E=1 and FlushM=1 for 3 cycles, ALU2DoneE=1 in cycle 4, then IDLE. Two back-to-back MACs → 3+3 stall cycles with one free cycle between.
- MAC in EX plus load-use condition in decode → FlushE stays 0 throughout BUSY; load-use is handled after release.
- RST_N=0 during BUSY cnt=1 → next cycle IDLE, ALU2DoneE never asserted, FlushE=FlushM=1 while in reset.
